// File: rtl/sample_demux_buf.sv
// Registered 1-to-N_CH sample demultiplexer with per-channel one-deep
// holding registers, SELECT / ROUND_ROBIN routing and a drop counter.
module sample_demux_buf #(
    parameter int DATA_W = 24,
    parameter int N_CH   = 8,
    parameter int CNT_W  = 16,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   mode,
    input  logic                   frame_sync,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic [DATA_W-1:0]      in_data,
    output logic [N_CH-1:0]        out_valid,
    input  logic [N_CH-1:0]        out_ready,
    output logic [N_CH*DATA_W-1:0] out_data,
    output logic                   drop_pulse,
    output logic [CNT_W-1:0]       drop_cnt
);

    logic [SEL_W-1:0]  tgt;
    logic              tgt_ok;
    logic              acc;
    logic              load;
    logic              drop;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [N_CH-1:0]   valid_q, valid_d;
    logic [DATA_W-1:0] data_q [N_CH];
    logic [DATA_W-1:0] data_d [N_CH];
    logic              drop_pulse_q;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    // A frame_sync sample always lands in channel 0, even mid-rotation.
    always_comb begin
        tgt      = mode ? (frame_sync ? '0 : rr_ptr_q) : in_sel;
        tgt_ok   = (32'(tgt) < 32'(N_CH));
        in_ready = 1'b1;
        if (tgt_ok) begin
            in_ready = ~valid_q[tgt] | out_ready[tgt];
        end
        acc  = in_valid & in_ready;
        load = acc & tgt_ok;
        drop = acc & ~tgt_ok;
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        for (int c = 0; c < N_CH; c++) begin
            if (load && (tgt == SEL_W'(c))) begin
                valid_d[c] = 1'b1;
                data_d[c]  = in_data;
            end else if (valid_q[c] && out_ready[c]) begin
                valid_d[c] = 1'b0;
                data_d[c]  = '0;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (frame_sync && acc && mode) begin
            rr_ptr_d = SEL_W'(1);
        end else if (frame_sync) begin
            rr_ptr_d = '0;
        end else if (acc && mode) begin
            if (rr_ptr_q == SEL_W'(N_CH - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = rr_ptr_q + SEL_W'(1);
            end
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q      <= '0;
            rr_ptr_q     <= '0;
            drop_pulse_q <= 1'b0;
            drop_cnt_q   <= '0;
            for (int c = 0; c < N_CH; c++) begin
                data_q[c] <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            rr_ptr_q     <= rr_ptr_d;
            drop_pulse_q <= drop;
            drop_cnt_q   <= drop_cnt_d;
            for (int c = 0; c < N_CH; c++) begin
                data_q[c] <= data_d[c];
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_out
        assign out_data[c*DATA_W +: DATA_W] = data_q[c];
    end

    assign out_valid  = valid_q;
    assign drop_pulse = drop_pulse_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_sample_demux_buf.sv
// Bench for sample_demux_buf: directed scenarios plus random traffic
// checked against a channel-array reference model.
module tb_sample_demux_buf;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         mode, fs, iv;
    logic [2:0]   sel;
    logic [23:0]  din;
    logic [7:0]   ordy;
    logic         irdy;
    logic [7:0]   ov;
    logic [191:0] od;
    logic         dp;
    logic [15:0]  dc;

    logic         mode6, fs6, iv6;
    logic [2:0]   sel6;
    logic [23:0]  din6;
    logic [5:0]   ordy6;
    logic         irdy6;
    logic [5:0]   ov6;
    logic [143:0] od6;
    logic         dp6;
    logic [1:0]   dc6;

    int n_vec = 0;
    int n_err = 0;

    bit          mv [8];
    logic [23:0] md [8];
    int          rr;
    int          dcnt;
    bit          dpm;

    always #5 clk = ~clk;

    sample_demux_buf u8 (
        .clk(clk), .reset_n(reset_n), .mode(mode), .frame_sync(fs),
        .in_valid(iv), .in_ready(irdy), .in_sel(sel), .in_data(din),
        .out_valid(ov), .out_ready(ordy), .out_data(od),
        .drop_pulse(dp), .drop_cnt(dc)
    );

    sample_demux_buf #(.DATA_W(24), .N_CH(6), .CNT_W(2)) u6 (
        .clk(clk), .reset_n(reset_n), .mode(mode6), .frame_sync(fs6),
        .in_valid(iv6), .in_ready(irdy6), .in_sel(sel6), .in_data(din6),
        .out_valid(ov6), .out_ready(ordy6), .out_data(od6),
        .drop_pulse(dp6), .drop_cnt(dc6)
    );

    task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        logic [191:0] pk;
        logic [7:0]   vk;
        for (int c = 0; c < 8; c++) begin
            pk[c*24 +: 24] = md[c];
            vk[c]          = mv[c];
        end
        check("out_valid", ov, vk);
        check("out_data", od, pk);
        check("drop_pulse", dp, dpm);
        check("drop_cnt", dc, dcnt);
    endtask

    task automatic model_clear();
        for (int c = 0; c < 8; c++) begin
            mv[c] = 1'b0;
            md[c] = '0;
        end
        rr   = 0;
        dcnt = 0;
        dpm  = 1'b0;
    endtask

    // One clock: check in_ready, advance the model on the edge, check outputs.
    task automatic cyc();
        int t;
        bit r, a;
        #1;
        t = mode ? (fs ? 0 : rr) : int'(sel);
        r = (t < 8) ? (!mv[t] || ordy[t]) : 1'b1;
        check("in_ready", irdy, r);
        @(posedge clk);
        a = iv && r;
        for (int c = 0; c < 8; c++) begin
            if (a && t < 8 && t == c) begin
                mv[c] = 1'b1;
                md[c] = din;
            end else if (mv[c] && ordy[c]) begin
                mv[c] = 1'b0;
                md[c] = '0;
            end
        end
        if (fs && a && mode) rr = 1;
        else if (fs) rr = 0;
        else if (a && mode) rr = (rr + 1) % 8;
        dpm = a && (t >= 8);
        if (dpm && dcnt < 65535) dcnt++;
        #1;
        check_model();
    endtask

    task automatic send(logic m, logic f, logic v, logic [2:0] s,
                        logic [23:0] d, logic [7:0] r);
        mode = m;
        fs   = f;
        iv   = v;
        sel  = s;
        din  = d;
        ordy = r;
        cyc();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        iv      = 1'b0;
        fs      = 1'b0;
        #1;
        model_clear();
        check_model();
        check("rst_valid", ov, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        mode = 0; fs = 0; iv = 0; sel = 0; din = 0; ordy = 0;
        mode6 = 0; fs6 = 0; iv6 = 0; sel6 = 0; din6 = 0; ordy6 = 0;
        #2;
        do_reset();

        // T1: select mode, channel 3 fills and then back-pressures
        send(0, 0, 1, 3, 24'h123456, 8'h00);
        check("t1_valid", ov, 8'h08);
        check("t1_data", od[3*24 +: 24], 24'h123456);
        din = 24'h654321;
        #1;
        check("t1_stall", irdy, 1'b0);
        cyc();
        send(0, 0, 0, 0, 0, 8'hff);
        check("t1_drain", ov, 8'h00);

        // T2: round robin wraps after N_CH samples
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            send(1, 0, 1, 0, 24'(i), 8'hff);
            check("t2_ch", od[((i - 1) % 8)*24 +: 24], 24'(i));
        end
        send(1, 0, 1, 0, 24'd11, 8'hff);
        check("t2_rrptr", ov, 8'h04);

        // T3: full round-robin target stalls, then load+drain together
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(1, 0, 1, 0, 24'(12'h100 + i), 8'hfb);
        end
        iv  = 1'b1;
        din = 24'h000777;
        #1;
        check("t3_stall", irdy, 1'b0);
        cyc();
        send(1, 0, 1, 0, 24'h000777, 8'hff);
        check("t3_keep", ov[2], 1'b1);
        check("t3_data", od[2*24 +: 24], 24'h000777);

        // T4: frame_sync realignment
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(1, 0, 1, 0, 24'(i), 8'hff);
        end
        send(1, 1, 1, 0, 24'h0000aa, 8'hff);
        check("t4_fs_ch0", ov, 8'h01);
        check("t4_fs_data", od[23:0], 24'h0000aa);
        send(1, 0, 1, 0, 24'h0000cc, 8'hff);
        check("t4_ptr1", ov, 8'h02);
        send(1, 1, 0, 0, 0, 8'hff);
        send(1, 0, 1, 0, 24'h0000bb, 8'hff);
        check("t4_ptr0", ov, 8'h01);
        check("t4_data0", od[23:0], 24'h0000bb);

        // T6: reset while channels hold samples
        do_reset();
        send(0, 0, 1, 1, 24'h000011, 8'h00);
        send(0, 0, 1, 4, 24'h000044, 8'h00);
        send(0, 0, 1, 6, 24'h000066, 8'h00);
        check("t6_full", ov, 8'h52);
        reset_n = 1'b0;
        #1;
        check("t6_valid", ov, 8'h00);
        check("t6_data", od, 192'h0);
        do_reset();
        send(1, 0, 1, 0, 24'h000005, 8'hff);
        check("t6_ptr0", ov, 8'h01);

        // random traffic
        for (int k = 0; k < 500; k++) begin
            send(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 3) != 0),
                 3'($urandom),
                 24'($urandom),
                 8'($urandom));
        end
        iv = 1'b0;
        fs = 1'b0;

        // T5: six channels, out-of-range select drops and saturates
        iv6  = 1'b1;
        sel6 = 3'd7;
        for (int k = 1; k <= 5; k++) begin
            din6 = 24'(k);
            #1;
            check("t5_ready", irdy6, 1'b1);
            @(posedge clk);
            #1;
            check("t5_pulse", dp6, 1'b1);
            check("t5_cnt", dc6, (k < 3) ? k : 3);
            check("t5_valid", ov6, 6'h00);
        end
        iv6 = 1'b0;
        @(posedge clk);
        #1;
        check("t5_pulse_end", dp6, 1'b0);
        iv6  = 1'b1;
        sel6 = 3'd5;
        din6 = 24'h000055;
        #1;
        check("t5_ready5", irdy6, 1'b1);
        @(posedge clk);
        #1;
        iv6 = 1'b0;
        check("t5_ch5", ov6, 6'h20);
        check("t5_data5", od6[5*24 +: 24], 24'h000055);
        check("t5_cnt_hold", dc6, 2'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
